// File: rtl/button_event_decoder_pkg.sv
// ============================================================================
// Module      : button_event_pkg
// Description : Shared types and sizing helpers for the button event decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

  localparam int CLICK_W = 8;

  // Hold counter must reach the larger of the two tick thresholds.
  function automatic int hold_cnt_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_decoder_if.sv
// ============================================================================
// Module      : button_event_decoder_if
// Description : Button level input and decoded event outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_event_decoder_if;
  import button_event_pkg::*;

  logic               btn_level;
  logic               held;
  logic               press_pulse;
  logic               release_pulse;
  logic               click_pulse;
  logic               long_pulse;
  logic               repeat_pulse;
  logic [CLICK_W-1:0] click_count;

  modport master (
    output btn_level,
    input  held, press_pulse, release_pulse, click_pulse, long_pulse,
    input  repeat_pulse, click_count
  );

  modport slave (
    input  btn_level,
    output held, press_pulse, release_pulse, click_pulse, long_pulse,
    output repeat_pulse, click_count
  );

endinterface

`default_nettype wire

// File: rtl/button_event_decoder_tick_gen.sv
// ============================================================================
// Module      : button_tick_gen
// Description : Free-running TICK_DIV prescaler with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clear,
  output logic      o_tick
);

  localparam int              CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced button level into press/release/click/long
//               (and, with BTN_AUTOREPEAT_EN defined, auto-repeat) pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int TICK_DIV     = 25000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input wire logic             clk,
  input wire logic             rst_n,
  button_event_decoder_if.slave bus
);

  localparam int             HCW         = hold_cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [HCW-1:0] C_LONG_LAST = HCW'(LONG_TICKS - 1);
  localparam logic [HCW-1:0] C_HOLD_MAX  = {HCW{1'b1}};
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HCW-1:0] C_REP_LAST  = HCW'(REPEAT_TICKS - 1);
`endif

  btn_state_e         r_state;
  btn_state_e         w_state_nxt;
  logic               r_prev;
  logic [HCW-1:0]     r_hold_cnt;
  logic               r_held;
  logic               r_press;
  logic               r_release;
  logic               r_click;
  logic               r_long;
  logic               r_repeat;
  logic [CLICK_W-1:0] r_click_count;

  logic               w_lvl;
  logic               w_rise;
  logic               w_fall;
  logic               w_tick;
  logic [HCW-1:0]     w_hold_nxt;
  logic               w_press_nxt;
  logic               w_release_nxt;
  logic               w_click_nxt;
  logic               w_long_nxt;
  logic               w_repeat_nxt;
  logic [CLICK_W-1:0] w_count_nxt;

  assign w_lvl  = bus.btn_level ^ ACTIVE_LOW;
  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  // Prescaler restarts on press so hold time is measured from the press edge.
  button_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_rise),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_HELD;
      ST_HELD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && (r_hold_cnt == C_LONG_LAST)) begin
          w_state_nxt = ST_LONG;
        end
      end
      ST_LONG: if (w_fall) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fall is tested first in every state so a release always beats a threshold.
  always_comb begin
    w_hold_nxt    = r_hold_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_click_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_count_nxt   = r_click_count;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_release_nxt = 1'b1;
          w_click_nxt   = 1'b1;
          w_count_nxt   = r_click_count + 1'b1;
        end else if (w_tick) begin
          if (r_hold_cnt == C_LONG_LAST) begin
            w_long_nxt = 1'b1;
            w_hold_nxt = '0;
          end else if (r_hold_cnt != C_HOLD_MAX) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_release_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        end else if (w_tick) begin
          if (r_hold_cnt == C_REP_LAST) begin
            w_repeat_nxt = 1'b1;
            w_hold_nxt   = '0;
          end else if (r_hold_cnt != C_HOLD_MAX) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev        <= 1'b0;
      r_hold_cnt    <= '0;
      r_held        <= 1'b0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_click       <= 1'b0;
      r_long        <= 1'b0;
      r_repeat      <= 1'b0;
      r_click_count <= '0;
    end else begin
      r_prev        <= w_lvl;
      r_hold_cnt    <= w_hold_nxt;
      r_held        <= (w_state_nxt != ST_IDLE);
      r_press       <= w_press_nxt;
      r_release     <= w_release_nxt;
      r_click       <= w_click_nxt;
      r_long        <= w_long_nxt;
      r_repeat      <= w_repeat_nxt;
      r_click_count <= w_count_nxt;
    end
  end

  assign bus.held          = r_held;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.click_pulse   = r_click;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.click_count   = r_click_count;

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Drives an active-high and an active-low decoder with the same
//               logical button activity and checks both against a hold-age model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event_decoder;

  localparam int TD       = 4;
  localparam int LT       = 5;
  localparam int RT       = 2;
  localparam int LONG_AGE = LT * TD;
  localparam int REP_AGE  = RT * TD;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  button_event_decoder_if if_ah ();
  button_event_decoder_if if_al ();

  button_event_decoder #(
    .TICK_DIV (TD), .LONG_TICKS (LT), .REPEAT_TICKS (RT), .ACTIVE_LOW (1'b0)
  ) dut_ah (
    .clk (clk), .rst_n (rst_n), .bus (if_ah)
  );

  button_event_decoder #(
    .TICK_DIV (TD), .LONG_TICKS (LT), .REPEAT_TICKS (RT), .ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk (clk), .rst_n (rst_n), .bus (if_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: age = clocks since the press edge; events fall out of arithmetic on it.
  bit       m_prev;
  bit       m_pressed;
  int       m_age;
  bit [7:0] m_count;
  bit       e_press, e_release, e_click, e_long, e_repeat;

  task automatic model_reset();
    m_prev    = 1'b0;
    m_pressed = 1'b0;
    m_age     = 0;
    m_count   = 8'd0;
    e_press   = 1'b0; e_release = 1'b0; e_click = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
  endtask

  task automatic model_edge(input bit lvl);
    bit rise, fall;
    rise = lvl & ~m_prev;
    fall = ~lvl & m_prev;
    m_prev = lvl;
    e_press = 1'b0; e_release = 1'b0; e_click = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
    if (!m_pressed) begin
      if (rise) begin
        e_press   = 1'b1;
        m_pressed = 1'b1;
        m_age     = 0;
      end
    end else begin
      m_age++;
      if (fall) begin
        e_release = 1'b1;
        m_pressed = 1'b0;
        if (m_age <= LONG_AGE) begin
          e_click = 1'b1;
          m_count = m_count + 8'd1;
        end
      end else if (m_age == LONG_AGE) begin
        e_long = 1'b1;
      end else if (REP_EN && (m_age > LONG_AGE) && (((m_age - LONG_AGE) % REP_AGE) == 0)) begin
        e_repeat = 1'b1;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [13:0] exp_v;
    exp_v = {m_pressed, e_press, e_release, e_click, e_long, e_repeat, m_count};
    check_eq("outputs_active_high",
             {18'd0, if_ah.held, if_ah.press_pulse, if_ah.release_pulse, if_ah.click_pulse,
              if_ah.long_pulse, if_ah.repeat_pulse, if_ah.click_count}, {18'd0, exp_v});
    check_eq("outputs_active_low",
             {18'd0, if_al.held, if_al.press_pulse, if_al.release_pulse, if_al.click_pulse,
              if_al.long_pulse, if_al.repeat_pulse, if_al.click_count}, {18'd0, exp_v});
  endtask

  task automatic step(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      if_ah.btn_level = lvl;
      if_al.btn_level = ~lvl;
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge(lvl);
      #1;
      compare_all();
    end
  endtask

  task automatic async_reset_pulse(input bit lvl, input int n_low);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    step(lvl, n_low);
    rst_n = 1'b1;
  endtask

  initial begin
    bit lvl;
    int run;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    if_ah.btn_level = 1'b0;
    if_al.btn_level = 1'b1;
    model_reset();
    #2;
    compare_all();
    step(1'b0, 3);
    rst_n = 1'b1;
    step(1'b0, 50);

    // Short press: click
    step(1'b1, 8);
    step(1'b0, 6);
    // Long press: long pulse, no click
    step(1'b1, 40);
    step(1'b0, 6);
    // Very long press: repeats when enabled
    step(1'b1, 60);
    step(1'b0, 12);
    // Fall lands on the long-threshold edge
    step(1'b1, LONG_AGE);
    step(1'b0, 6);
    // One clock shorter and one longer around the threshold
    step(1'b1, LONG_AGE - 1);
    step(1'b0, 3);
    step(1'b1, LONG_AGE + 1);
    step(1'b0, 3);
    // Reset mid-hold, button still held on release of reset
    step(1'b1, 10);
    async_reset_pulse(1'b1, 3);
    step(1'b1, 30);
    step(1'b0, 5);

    lvl = 1'b0;
    for (int k = 0; k < 70; k++) begin
      lvl = ~lvl;
      run = $urandom_range(1, 70);
      if (($urandom % 15) == 0) begin
        step(lvl, run / 2 + 1);
        async_reset_pulse(lvl, $urandom_range(1, 3));
      end
      step(lvl, run);
    end
    step(1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
